// File: rtl/prog_pwm_multi.sv
// prog_pwm_multi - multi-channel programmable square-wave / PWM generator.
//
// A shared prescaler produces a tick every presc+1 clocks. Each channel runs
// an IDLE/ON/OFF machine that counts on_len ticks high, then off_len ticks low.
// Interval lengths are written into shadow registers and copied into the
// active registers only when a channel starts or at a period boundary, so a
// reprogram never cuts a running interval short.
//
// Optional build macro: PWM_POLARITY_CTRL_EN
//   When defined, adds input pol[CH]. Each output is then the internal
//   waveform XOR pol, applied combinationally, so it also follows pol in IDLE
//   and while reset is asserted.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   presc        tick period minus one (hold static while running)
//   wr_en        shadow register write strobe
//   wr_ch        channel index for the write (indices >= CH are ignored)
//   wr_on/wr_off on / off lengths in ticks for the write
//   enable       per-channel run enable
//   pol          per-channel output inversion (PWM_POLARITY_CTRL_EN only)
//   pwm_o        registered waveform outputs
//   period_done  one-clock pulse per channel after each completed period
module prog_pwm_multi #(
    parameter int N       = 8,
    parameter int CH      = 4,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRESC_W-1:0] presc,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [N-1:0]       wr_on,
    input  logic [N-1:0]       wr_off,
    input  logic [CH-1:0]      enable,
`ifdef PWM_POLARITY_CTRL_EN
    input  logic [CH-1:0]      pol,
`endif
    output logic [CH-1:0]      pwm_o,
    output logic [CH-1:0]      period_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    // ---------------- shared prescaler ----------------
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               tick;

    assign tick        = (presc_cnt_q == presc);
    assign presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) presc_cnt_q <= '0;
        else       presc_cnt_q <= presc_cnt_d;
    end

    logic [CH-1:0] pwm_int;
    logic [CH-1:0] done_int;

    // ---------------- per-channel generators ----------------
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [N-1:0] shadow_on_q, shadow_off_q;
        logic [N-1:0] on_q, on_d, off_q, off_d, cnt_q, cnt_d;
        logic [N-1:0] load_on, load_off;
        state_t       state_q, state_d;
        logic         pwm_q, pwm_d, done_q, done_d;
        logic         wr_hit;

        // Index widths larger than needed leave out-of-range indices
        // unmatched by every channel, so such writes are dropped.
        assign wr_hit = wr_en && (wr_ch == CH_W'(gi));

        // A write landing in a load cycle is forwarded straight into the
        // active registers, so the new values govern the period starting now.
        assign load_on  = wr_hit ? wr_on  : shadow_on_q;
        assign load_off = wr_hit ? wr_off : shadow_off_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_on_q  <= '0;
                shadow_off_q <= '0;
            end else if (wr_hit) begin
                shadow_on_q  <= wr_on;
                shadow_off_q <= wr_off;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            on_d    = on_q;
            off_d   = off_q;
            done_d  = 1'b0;
            if (!enable[gi]) begin
                // Disable wins immediately, without waiting for a tick.
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        on_d    = load_on;
                        off_d   = load_off;
                        cnt_d   = '0;
                        state_d = (load_on != '0) ? ST_ON : ST_OFF;
                    end
                    ST_ON: begin
                        // on_q is never zero here: ON is only entered with on_len > 0.
                        if (cnt_q == on_q - ONE) begin
                            cnt_d = '0;
                            if (off_q != '0) begin
                                state_d = ST_OFF;
                            end else begin
                                done_d  = 1'b1;
                                on_d    = load_on;
                                off_d   = load_off;
                                state_d = (load_on != '0) ? ST_ON : ST_OFF;
                            end
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    ST_OFF: begin
                        if (off_q == '0) begin
                            // Both lengths zero: idle-low, re-sample shadow every
                            // tick, and never report a period.
                            cnt_d   = '0;
                            on_d    = load_on;
                            off_d   = load_off;
                            state_d = (load_on != '0) ? ST_ON : ST_OFF;
                        end else if (cnt_q == off_q - ONE) begin
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            on_d    = load_on;
                            off_d   = load_off;
                            state_d = (load_on != '0) ? ST_ON : ST_OFF;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            pwm_d = (state_d == ST_ON);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                on_q    <= '0;
                off_q   <= '0;
                pwm_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                on_q    <= on_d;
                off_q   <= off_d;
                pwm_q   <= pwm_d;
                done_q  <= done_d;
            end
        end

        assign pwm_int[gi]  = pwm_q;
        assign done_int[gi] = done_q;
    end

`ifdef PWM_POLARITY_CTRL_EN
    assign pwm_o = pwm_int ^ pol;
`else
    assign pwm_o = pwm_int;
`endif
    assign period_done = done_int;

endmodule

// File: tb/tb_prog_pwm_multi.sv
module tb_prog_pwm_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] presc;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_on, wr_off;
    logic [3:0] enable;
    logic [3:0] pwm_o, period_done;

    prog_pwm_multi #(.N(8), .CH(4), .PRESC_W(8)) dut (
        .clk(clk), .reset(reset), .presc(presc), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_on(wr_on), .wr_off(wr_off), .enable(enable),
        .pwm_o(pwm_o), .period_done(period_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each running channel tracks its position (in ticks)
    // inside the current period; high while pos < on_len.
    int         m_pc;
    int         m_sh_on[4], m_sh_off[4], m_on[4], m_off[4], m_pos[4];
    bit         m_run[4];
    logic [3:0] m_pwm, m_done;

    // Run-length measurement on DUT outputs.
    int   run_len[4], last_hi[4], last_lo[4], since_done[4], last_gap[4];
    logic prev_lvl[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int c = 0; c < 4; c++) begin
            m_sh_on[c] = 0; m_sh_off[c] = 0; m_on[c] = 0; m_off[c] = 0;
            m_pos[c] = 0; m_run[c] = 0;
        end
        m_pwm = '0; m_done = '0;
    endtask

    task automatic model_edge();
        bit t;
        t = (m_pc == int'(presc));
        m_pc = t ? 0 : m_pc + 1;
        if (wr_en) begin
            m_sh_on[wr_ch]  = int'(wr_on);
            m_sh_off[wr_ch] = int'(wr_off);
        end
        for (int c = 0; c < 4; c++) begin
            m_done[c] = 1'b0;
            if (!enable[c]) begin
                m_run[c] = 0; m_pos[c] = 0;
            end else if (t) begin
                if (!m_run[c]) begin
                    m_run[c] = 1; m_pos[c] = 0;
                    m_on[c] = m_sh_on[c]; m_off[c] = m_sh_off[c];
                end else if (m_on[c] + m_off[c] == 0) begin
                    m_pos[c] = 0;
                    m_on[c] = m_sh_on[c]; m_off[c] = m_sh_off[c];
                end else begin
                    m_pos[c]++;
                    if (m_pos[c] == m_on[c] + m_off[c]) begin
                        m_done[c] = 1'b1;
                        m_pos[c] = 0;
                        m_on[c] = m_sh_on[c]; m_off[c] = m_sh_off[c];
                    end
                end
            end
            m_pwm[c] = m_run[c] && (m_pos[c] < m_on[c]);
        end
    endtask

    task automatic clear_meas();
        for (int c = 0; c < 4; c++) begin
            run_len[c] = 0; last_hi[c] = -1; last_lo[c] = -1;
            since_done[c] = 0; last_gap[c] = -1; prev_lvl[c] = pwm_o[c];
        end
    endtask

    task automatic measure();
        for (int c = 0; c < 4; c++) begin
            if (pwm_o[c] === prev_lvl[c]) run_len[c]++;
            else begin
                if (prev_lvl[c] === 1'b1) last_hi[c] = run_len[c];
                else last_lo[c] = run_len[c];
                run_len[c] = 1;
            end
            prev_lvl[c] = pwm_o[c];
            since_done[c]++;
            if (period_done[c] === 1'b1) begin
                last_gap[c] = since_done[c];
                since_done[c] = 0;
            end
        end
    endtask

    // One clock: model steps at the edge, DUT sampled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pwm_o", 32'(pwm_o), 32'(m_pwm));
        chk("period_done", 32'(period_done), 32'(m_done));
        measure();
    endtask

    task automatic write(input int ch, input int on, input int off);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_on = 8'(on); wr_off = 8'(off);
        $display("WRITE ch=%0d on=%0d off=%0d t=%0t", ch, on, off, $time);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_level(input int ch, input logic lvl, input int budget);
        int k;
        k = 0;
        while (pwm_o[ch] !== lvl && k < budget) begin
            cyc();
            k++;
        end
        n_cmp++;
        assert (pwm_o[ch] === lvl) else begin
            n_bad++;
            $error("FAIL wait_ch%0d observed=%0b expected=%0b (timeout)", ch, pwm_o[ch], lvl);
        end
    endtask

    task automatic do_reset(input int p);
        presc = 8'(p); enable = '0; wr_en = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        $display("RESET presc=%0d t=%0t", p, $time);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1; presc = 8'd4; wr_en = 1'b0; wr_ch = '0;
        wr_on = '0; wr_off = '0; enable = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_pwm", 32'(pwm_o), 32'd0);
        chk("reset_done", 32'(period_done), 32'd0);
        reset = 1'b0;
        $display("RESET released t=%0t", $time);

        // Basic timing: presc=4, on=3, off=2.
        write(0, 3, 2);
        enable = 4'b0001;
        clear_meas();
        repeat (100) cyc();
        chk("ch0_high_clocks", last_hi[0], 15);
        chk("ch0_low_clocks", last_lo[0], 10);
        chk("ch0_period_clocks", last_gap[0], 25);

        // Asynchronous reset while ch0 is high.
        wait_level(0, 1'b1, 50);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_pwm", 32'(pwm_o), 32'd0);
        chk("async_reset_done", 32'(period_done), 32'd0);
        $display("ASYNC RESET applied t=%0t", $time);
        @(negedge clk);
        enable = '0;
        reset = 1'b0;
        model_reset();
        repeat (12) cyc();

        // Glitch-free update mid-ON.
        do_reset(1);
        write(1, 4, 4);
        enable = 4'b0010;
        clear_meas();
        wait_level(1, 1'b1, 40);
        cyc(); cyc();
        write(1, 1, 7);
        wait_level(1, 1'b0, 40);
        chk("ch1_old_high", last_hi[1], 8);
        wait_level(1, 1'b1, 40);
        chk("ch1_old_low", last_lo[1], 8);
        wait_level(1, 1'b0, 40);
        chk("ch1_new_high", last_hi[1], 2);
        wait_level(1, 1'b1, 60);
        chk("ch1_new_low", last_lo[1], 14);
        chk("ch1_period", last_gap[1], 16);

        // Degenerate lengths at presc=0.
        do_reset(0);
        write(2, 0, 5);
        enable = 4'b0100;
        clear_meas();
        repeat (30) cyc();
        chk("ch2_off_only_gap", last_gap[2], 5);
        chk("ch2_off_only_level", 32'(pwm_o[2]), 32'd0);
        write(2, 6, 0);
        repeat (30) cyc();
        chk("ch2_on_only_gap", last_gap[2], 6);
        chk("ch2_on_only_level", 32'(pwm_o[2]), 32'd1);

        // Independence and disable.
        do_reset(1);
        write(0, 2, 3); write(1, 3, 1); write(2, 1, 4); write(3, 4, 2);
        enable = 4'hF;
        repeat (30) cyc();
        wait_level(3, 1'b1, 40);
        cyc();
        enable[3] = 1'b0;
        cyc();
        chk("ch3_disabled_pwm", 32'(pwm_o[3]), 32'd0);
        chk("ch3_disabled_done", 32'(period_done[3]), 32'd0);
        repeat (10) cyc();
        enable[3] = 1'b1;
        clear_meas();
        wait_level(3, 1'b1, 20);
        wait_level(3, 1'b0, 20);
        chk("ch3_restart_high", last_hi[3], 8);

        // Write colliding with a period boundary on ch0.
        do_reset(1);
        write(0, 3, 2);
        enable = 4'b0001;
        repeat (20) cyc();
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_pc == int'(presc) && m_run[0] && m_pos[0] + 1 == m_on[0] + m_off[0]) found = 1;
            else cyc();
        end
        n_cmp++;
        assert (found) else begin
            n_bad++;
            $error("FAIL boundary_search observed=%0b expected=1", found);
        end
        clear_meas();
        write(0, 2, 3);
        wait_level(0, 1'b0, 30);
        chk("collision_high", last_hi[0], 4);
        wait_level(0, 1'b1, 30);
        chk("collision_low", last_lo[0], 6);

        // Randomized traffic against the model.
        do_reset($urandom_range(0, 2));
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0)
                write($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5));
            else begin
                if ($urandom_range(0, 29) == 0) enable[$urandom_range(0, 3)] ^= 1'b1;
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
